// File: rtl/muntjac_fetch_arbiter.sv
// Shares one I$ request port between demand (m0) and prefetch (m1) fetch; request path is combinational.
// Responses return in order through a tag FIFO; requests stall while MaxOutstanding are in flight.
module muntjac_fetch_arbiter #(
  parameter int MaxOutstanding = 2,
  parameter int StarveLimit    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_valid_i,
  output logic        m0_req_ready_o,
  input  logic [63:0] m0_req_pc_i,
  input  logic        m1_req_valid_i,
  output logic        m1_req_ready_o,
  input  logic [63:0] m1_req_pc_i,

  output logic        m0_resp_valid_o,
  output logic [31:0] m0_resp_instr_o,
  output logic        m0_resp_exception_o,
  output logic        m1_resp_valid_o,
  output logic [31:0] m1_resp_instr_o,
  output logic        m1_resp_exception_o,

  output logic        cache_req_valid_o,
  input  logic        cache_req_ready_i,
  output logic [63:0] cache_req_pc_o,
  input  logic        cache_resp_valid_i,
  input  logic [31:0] cache_resp_instr_i,
  input  logic        cache_resp_exception_i,

  input  logic        flush_i,
  output logic        protocol_err_o
);

  logic [2:0] count_q;
  logic [1:0] rd_ptr_q;
  logic [1:0] wr_ptr_q;
  logic [3:0] id_q;
  logic [3:0] drop_q;
  logic [3:0] starve_q;
  logic       hold_q;
  logic       hold_sel_q;
  logic       protocol_err_q;

  logic any_valid;
  logic slot_free;
  logic starve_hit;
  logic held_still_valid;
  logic sel;
  logic push;
  logic pop;
  logic unexpected;
  logic head_id;
  logic head_drop;
  logic deliver;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(MaxOutstanding - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // A stalled handshake keeps its requester unless that requester withdraws.
  always_comb begin
    starve_hit       = (starve_q == 4'(StarveLimit)) && m1_req_valid_i;
    held_still_valid = hold_sel_q ? m1_req_valid_i : m0_req_valid_i;
    if (hold_q && held_still_valid) begin
      sel = hold_sel_q;
    end else if (starve_hit) begin
      sel = 1'b1;
    end else begin
      sel = !m0_req_valid_i;
    end
  end

  assign any_valid = m0_req_valid_i || m1_req_valid_i;
  assign slot_free = (count_q < 3'(MaxOutstanding)) ||
                     ((count_q == 3'(MaxOutstanding)) && cache_resp_valid_i);

  assign cache_req_valid_o = !rst_i && !flush_i && any_valid && slot_free;
  assign cache_req_pc_o    = sel ? m1_req_pc_i : m0_req_pc_i;

  assign push           = cache_req_valid_o && cache_req_ready_i;
  assign m0_req_ready_o = push && !sel;
  assign m1_req_ready_o = push && sel;

  assign pop        = cache_resp_valid_i && (count_q != 3'd0);
  assign unexpected = cache_resp_valid_i && (count_q == 3'd0);
  assign head_id    = id_q[rd_ptr_q];
  assign head_drop  = drop_q[rd_ptr_q];
  // A flush also kills the response being popped in the same cycle.
  assign deliver    = !rst_i && pop && !head_drop && !flush_i;

  assign m0_resp_valid_o     = deliver && !head_id;
  assign m1_resp_valid_o     = deliver && head_id;
  assign m0_resp_instr_o     = m0_resp_valid_o ? cache_resp_instr_i : 32'd0;
  assign m1_resp_instr_o     = m1_resp_valid_o ? cache_resp_instr_i : 32'd0;
  assign m0_resp_exception_o = m0_resp_valid_o && cache_resp_exception_i;
  assign m1_resp_exception_o = m1_resp_valid_o && cache_resp_exception_i;

  assign protocol_err_o = protocol_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q        <= 3'd0;
      rd_ptr_q       <= 2'd0;
      wr_ptr_q       <= 2'd0;
      id_q           <= 4'd0;
      drop_q         <= 4'd0;
      starve_q       <= 4'd0;
      hold_q         <= 1'b0;
      hold_sel_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
        id_q[wr_ptr_q] <= sel;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + 3'(push) - 3'(pop);

      // No grant can happen in a flush cycle, so the two writes never collide.
      if (flush_i) begin
        drop_q <= 4'hf;
      end else if (push) begin
        drop_q[wr_ptr_q] <= 1'b0;
      end

      if (unexpected) begin
        protocol_err_q <= 1'b1;
      end

      if (!m1_req_valid_i || m1_req_ready_o) begin
        starve_q <= 4'd0;
      end else if (starve_q != 4'(StarveLimit)) begin
        starve_q <= starve_q + 4'd1;
      end

      hold_q     <= cache_req_valid_o && !cache_req_ready_i;
      hold_sel_q <= sel;
    end
  end

endmodule

// File: tb/tb_muntjac_fetch_arbiter.sv
// Directed bench for muntjac_fetch_arbiter: per-cycle vector table plus starvation, stall and reset sequences.
module tb_muntjac_fetch_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_valid_i, m1_req_valid_i;
  logic        m0_req_ready_o, m1_req_ready_o;
  logic [63:0] m0_req_pc_i, m1_req_pc_i;
  logic        m0_resp_valid_o, m1_resp_valid_o;
  logic [31:0] m0_resp_instr_o, m1_resp_instr_o;
  logic        m0_resp_exception_o, m1_resp_exception_o;
  logic        cache_req_valid_o, cache_req_ready_i;
  logic [63:0] cache_req_pc_o;
  logic        cache_resp_valid_i;
  logic [31:0] cache_resp_instr_i;
  logic        cache_resp_exception_i;
  logic        flush_i;
  logic        protocol_err_o;

  always #5 clk_i = ~clk_i;

  muntjac_fetch_arbiter #(.MaxOutstanding(2), .StarveLimit(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o), .m0_req_pc_i(m0_req_pc_i),
    .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o), .m1_req_pc_i(m1_req_pc_i),
    .m0_resp_valid_o(m0_resp_valid_o), .m0_resp_instr_o(m0_resp_instr_o),
    .m0_resp_exception_o(m0_resp_exception_o),
    .m1_resp_valid_o(m1_resp_valid_o), .m1_resp_instr_o(m1_resp_instr_o),
    .m1_resp_exception_o(m1_resp_exception_o),
    .cache_req_valid_o(cache_req_valid_o), .cache_req_ready_i(cache_req_ready_i),
    .cache_req_pc_o(cache_req_pc_o),
    .cache_resp_valid_i(cache_resp_valid_i), .cache_resp_instr_i(cache_resp_instr_i),
    .cache_resp_exception_i(cache_resp_exception_i),
    .flush_i(flush_i), .protocol_err_o(protocol_err_o)
  );

  typedef struct {
    logic        m0v, m1v;
    logic [63:0] pc0, pc1;
    logic        crdy, rv;
    logic [31:0] instr;
    logic        exc, fl;
    logic        e_cv;
    logic [63:0] e_pc;
    logic        e_r0, e_r1, e_v0, e_v1;
    logic [31:0] e_i0, e_i1;
    logic        e_x0, e_x1, e_perr;
  } vec_t;

  localparam int NVec = 20;
  vec_t vecs [NVec];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0;
    m0_req_pc_i = 64'd0;   m1_req_pc_i = 64'd0;
    cache_req_ready_i = 1'b0; cache_resp_valid_i = 1'b0;
    cache_resp_instr_i = 32'd0; cache_resp_exception_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    m0_req_valid_i = v.m0v;  m1_req_valid_i = v.m1v;
    m0_req_pc_i = v.pc0;     m1_req_pc_i = v.pc1;
    cache_req_ready_i = v.crdy; cache_resp_valid_i = v.rv;
    cache_resp_instr_i = v.instr; cache_resp_exception_i = v.exc;
    flush_i = v.fl;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk1($sformatf("v%0d.cache_req_valid", i), cache_req_valid_o, v.e_cv);
    if (v.e_cv) chkw($sformatf("v%0d.cache_req_pc", i), cache_req_pc_o, v.e_pc);
    chk1($sformatf("v%0d.m0_ready", i), m0_req_ready_o, v.e_r0);
    chk1($sformatf("v%0d.m1_ready", i), m1_req_ready_o, v.e_r1);
    chk1($sformatf("v%0d.m0_resp_valid", i), m0_resp_valid_o, v.e_v0);
    chk1($sformatf("v%0d.m1_resp_valid", i), m1_resp_valid_o, v.e_v1);
    chkw($sformatf("v%0d.m0_instr", i), 64'(m0_resp_instr_o), 64'(v.e_i0));
    chkw($sformatf("v%0d.m1_instr", i), 64'(m1_resp_instr_o), 64'(v.e_i1));
    chk1($sformatf("v%0d.m0_exc", i), m0_resp_exception_o, v.e_x0);
    chk1($sformatf("v%0d.m1_exc", i), m1_resp_exception_o, v.e_x1);
    chk1($sformatf("v%0d.protocol_err", i), protocol_err_o, v.e_perr);
  endtask

  initial begin
    // m0v m1v pc0 pc1 crdy rv instr exc fl | cv pc r0 r1 v0 v1 i0 i1 x0 x1 perr
    // In-order routing of an m0 then an m1 fetch.
    vecs[0]  = '{1, 0, 64'h1000, 64'h0, 1, 0, 32'h0, 0, 0, 1, 64'h1000, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[1]  = '{0, 1, 64'h0, 64'h2000, 1, 0, 32'h0, 0, 0, 1, 64'h2000, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[2]  = '{0, 0, 64'h0, 64'h0, 0, 1, 32'hAAAA0001, 0, 0, 0, 64'h0, 0, 0, 1, 0, 32'hAAAA0001, 32'h0, 0, 0, 0};
    vecs[3]  = '{0, 0, 64'h0, 64'h0, 0, 1, 32'hBBBB0002, 1, 0, 0, 64'h0, 0, 0, 0, 1, 32'h0, 32'hBBBB0002, 0, 1, 0};
    // Fill to two outstanding, stall when full, then grant alongside a response.
    vecs[4]  = '{1, 0, 64'h3000, 64'h0, 1, 0, 32'h0, 0, 0, 1, 64'h3000, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[5]  = '{1, 0, 64'h3004, 64'h0, 1, 0, 32'h0, 0, 0, 1, 64'h3004, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[6]  = '{1, 0, 64'h3008, 64'h0, 1, 0, 32'h0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[7]  = '{1, 0, 64'h3008, 64'h0, 1, 1, 32'h11110003, 0, 0, 1, 64'h3008, 1, 0, 1, 0, 32'h11110003, 32'h0, 0, 0, 0};
    // Flush with two in flight: both late responses dropped, then normal service.
    vecs[8]  = '{1, 0, 64'h4000, 64'h0, 1, 0, 32'h0, 0, 1, 0, 64'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[9]  = '{0, 0, 64'h0, 64'h0, 0, 1, 32'h22220004, 0, 0, 0, 64'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[10] = '{0, 0, 64'h0, 64'h0, 0, 1, 32'h33330005, 0, 0, 0, 64'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[11] = '{1, 0, 64'h4000, 64'h0, 1, 0, 32'h0, 0, 0, 1, 64'h4000, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[12] = '{0, 0, 64'h0, 64'h0, 0, 1, 32'h44440006, 1, 0, 0, 64'h0, 0, 0, 1, 0, 32'h44440006, 32'h0, 1, 0, 0};
    // Flush in the same cycle as a response, with a free slot: no grant, response dropped.
    vecs[13] = '{1, 0, 64'h5000, 64'h0, 1, 0, 32'h0, 0, 0, 1, 64'h5000, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[14] = '{1, 0, 64'h5008, 64'h0, 1, 1, 32'h55550007, 0, 1, 0, 64'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[15] = '{1, 0, 64'h5008, 64'h0, 1, 0, 32'h0, 0, 0, 1, 64'h5008, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[16] = '{0, 0, 64'h0, 64'h0, 0, 1, 32'h66660008, 0, 0, 0, 64'h0, 0, 0, 1, 0, 32'h66660008, 32'h0, 0, 0, 0};
    // Response with nothing outstanding: ignored, sticky error from the next cycle.
    vecs[17] = '{0, 0, 64'h0, 64'h0, 0, 1, 32'h77770009, 1, 0, 0, 64'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
    vecs[18] = '{0, 0, 64'h0, 64'h0, 0, 0, 32'h0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1};
    vecs[19] = '{1, 0, 64'h6000, 64'h0, 1, 0, 32'h0, 0, 0, 1, 64'h6000, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1};

    rst_i = 1'b1;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1;
    cache_req_ready_i = 1'b1; cache_resp_valid_i = 1'b1;
    #3;
    chk1("rst.cache_req_valid", cache_req_valid_o, 1'b0);
    chk1("rst.m0_ready", m0_req_ready_o, 1'b0);
    chk1("rst.m1_ready", m1_req_ready_o, 1'b0);
    chk1("rst.m0_resp_valid", m0_resp_valid_o, 1'b0);
    chk1("rst.m1_resp_valid", m1_resp_valid_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle();
    #3;
    chk1("rst.protocol_err", protocol_err_o, 1'b0);

    for (int i = 0; i < NVec; i++) begin
      @(posedge clk_i);
      #1;
      drive(vecs[i]);
      #3;
      check_vec(i, vecs[i]);
    end

    // Reset clears the sticky error and the leftover in-flight entry.
    @(posedge clk_i);
    #1;
    idle();
    rst_i = 1'b1;
    m0_req_valid_i = 1'b1; cache_resp_valid_i = 1'b1;
    #3;
    chk1("rst2.cache_req_valid", cache_req_valid_o, 1'b0);
    chk1("rst2.m0_resp_valid", m0_resp_valid_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle();
    #3;
    chk1("rst2.protocol_err", protocol_err_o, 1'b0);

    // Starvation: m0 wins four cycles, m1 forced on the fifth, then m0 again.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i);
      #1;
      idle();
      m0_req_valid_i = 1'b1; m0_req_pc_i = 64'hA000;
      m1_req_valid_i = 1'b1; m1_req_pc_i = 64'hB000;
      cache_req_ready_i = 1'b1;
      cache_resp_valid_i = (i > 0);
      cache_resp_instr_i = 32'hC0DE0000 + 32'(i);
      #3;
      chk1($sformatf("starve%0d.m0_ready", i), m0_req_ready_o, i != 4);
      chk1($sformatf("starve%0d.m1_ready", i), m1_req_ready_o, i == 4);
      chkw($sformatf("starve%0d.pc", i), cache_req_pc_o, (i == 4) ? 64'hB000 : 64'hA000);
      chk1($sformatf("starve%0d.m0_resp_valid", i), m0_resp_valid_o, (i > 0) && (i != 5));
      chk1($sformatf("starve%0d.m1_resp_valid", i), m1_resp_valid_o, i == 5);
    end
    @(posedge clk_i);
    #1;
    idle();
    cache_resp_valid_i = 1'b1; cache_resp_instr_i = 32'hC0DE0006;
    #3;
    chk1("starve_drain.m0_resp_valid", m0_resp_valid_o, 1'b1);
    chkw("starve_drain.m0_instr", 64'(m0_resp_instr_o), 64'hC0DE0006);

    // Stall with m1 selected; m0 arriving mid-stall must not steal the handshake.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      idle();
      m1_req_valid_i = (i < 4); m1_req_pc_i = 64'hC000;
      m0_req_valid_i = (i > 0); m0_req_pc_i = 64'hD000;
      cache_req_ready_i = (i >= 3);
      #3;
      chk1($sformatf("stall%0d.cache_req_valid", i), cache_req_valid_o, 1'b1);
      chkw($sformatf("stall%0d.pc", i), cache_req_pc_o, (i < 4) ? 64'hC000 : 64'hD000);
      chk1($sformatf("stall%0d.m1_ready", i), m1_req_ready_o, i == 3);
      chk1($sformatf("stall%0d.m0_ready", i), m0_req_ready_o, i == 4);
    end
    @(posedge clk_i);
    #1;
    idle();
    cache_resp_valid_i = 1'b1; cache_resp_instr_i = 32'h12340001;
    #3;
    chk1("stall_resp0.m1_resp_valid", m1_resp_valid_o, 1'b1);
    chk1("stall_resp0.m0_resp_valid", m0_resp_valid_o, 1'b0);
    chkw("stall_resp0.m1_instr", 64'(m1_resp_instr_o), 64'h12340001);
    @(posedge clk_i);
    #1;
    cache_resp_instr_i = 32'h12340002;
    #3;
    chk1("stall_resp1.m0_resp_valid", m0_resp_valid_o, 1'b1);
    chk1("stall_resp1.m1_resp_valid", m1_resp_valid_o, 1'b0);
    chkw("stall_resp1.m0_instr", 64'(m0_resp_instr_o), 64'h12340002);
    @(posedge clk_i);
    #1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muntjac_fetch_arbiter.md
MUNTJAC_FETCH_ARBITER -- requirements
Module: muntjac_fetch_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2; max cache requests in flight (1..4).
REQ-002 SHALL have parameter StarveLimit, default 4; consecutive lost cycles before requester 1 is force-granted (1..15).
REQ-003 SHALL have port clk_i, input, 1; sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1; reset, synchronous, active-high.
REQ-005 SHALL have ports m0_req_valid_i in 1, m0_req_ready_o out 1, m0_req_pc_i in 64; demand-fetch requester.
REQ-006 SHALL have ports m1_req_valid_i in 1, m1_req_ready_o out 1, m1_req_pc_i in 64; prefetch requester.
REQ-007 SHALL have ports m0_resp_valid_o out 1, m0_resp_instr_o out 32, m0_resp_exception_o out 1.
REQ-008 SHALL have ports m1_resp_valid_o out 1, m1_resp_instr_o out 32, m1_resp_exception_o out 1.
REQ-009 SHALL have ports cache_req_valid_o out 1, cache_req_ready_i in 1, cache_req_pc_o out 64; shared I$ request port.
REQ-010 SHALL have ports cache_resp_valid_i in 1, cache_resp_instr_i in 32, cache_resp_exception_i in 1; no response backpressure.
REQ-011 SHALL have port flush_i, input, 1; discard all in-flight responses (redirect).
REQ-012 SHALL have port protocol_err_o, output, 1; sticky unexpected-response flag.

Function
REQ-013 SHALL select m1 when starve count == StarveLimit and m1_req_valid_i; otherwise m0 if valid, else m1 if valid.
REQ-014 SHALL drive cache_req_valid_o = (m0 or m1 valid) and slot_free and !flush_i; cache_req_pc_o = selected PC, combinationally.
REQ-015 SHALL define slot_free = outstanding < MaxOutstanding, or outstanding == MaxOutstanding with cache_resp_valid_i this cycle.
REQ-016 SHALL assert mX_req_ready_o only for the selected requester, and only when cache_req_valid_o and cache_req_ready_i; grant = that handshake.
REQ-017 SHALL hold selection stable while cache_req_valid_o is high and cache_req_ready_i low (no switch mid-handshake, unless the held requester drops valid).
REQ-018 SHALL increment 4-bit starve count each cycle m1 is valid and not granted, saturating at StarveLimit; clear on m1 grant or m1 valid low.
REQ-019 SHALL push {id, drop=0} into an in-order tag FIFO of depth MaxOutstanding on each grant.
REQ-020 SHALL pop the FIFO head on each cache_resp_valid_i; route data/exception to m{id} with resp_valid high for exactly that cycle, unless drop=1 (no resp_valid).
REQ-021 SHALL support push and pop in the same cycle at full occupancy; count unchanged.
REQ-022 SHALL, on flush_i, set drop=1 on every FIFO entry, including one popped this cycle (its response is suppressed); no grant occurs in a flush cycle.
REQ-023 SHALL, on cache_resp_valid_i with empty FIFO, ignore the response, emit no resp_valid, and set protocol_err_o until reset.
REQ-024 SHALL hold mX_resp_instr_o/exception_o at zero when the corresponding resp_valid is low.
REQ-025 SHALL never assert both m0_resp_valid_o and m1_resp_valid_o in one cycle.

Reset
REQ-026 SHALL, with rst_i high at a clock edge, clear FIFO, outstanding count, starve count and protocol_err_o; in-flight responses after reset count as unexpected.
REQ-027 SHALL hold all ready/valid outputs low while rst_i is high; next cycle after release is fully operational.

Verification
REQ-028 Both valid, cache_req_ready_i=1, StarveLimit=4 -> m0 granted cycles 0-3, m1 granted cycle 4, count cleared, m0 granted cycle 5.
REQ-029 Grants m0 pc=0x1000, then m1 pc=0x2000; responses 0xAAAA0001, 0xBBBB0002 -> m0_resp_valid_o with 0xAAAA0001, then m1_resp_valid_o with 0xBBBB0002.
REQ-030 Two outstanding, m0 valid; response arrives same cycle -> m0 granted that cycle, outstanding stays 2.
REQ-031 Two outstanding, flush_i pulsed; m0 request same cycle -> no grant that cycle; both later responses suppressed; new grant and its response delivered normally.
REQ-032 cache_resp_valid_i with nothing outstanding -> no resp_valid, protocol_err_o=1 persists until rst_i, cleared to 0 after reset.
REQ-033 cache_req_ready_i=0 for 3 cycles with m1 selected, m0 rises mid-stall -> cache_req_pc_o stays m1 PC until accepted.
